imem_loader: RTL

Synthesizable boot loader and run controller for the single-cycle `xgriscv_sc` core. It takes the role that `$readmemh` and the PC watchdog play in simulation, so the core can run on hardware. A byte stream fills instruction memory over a valid/ready handshake, then the core's reset is released. The block counts core clock cycles and stops the core when the write-back PC reaches a programmed halt address. It sits between the host byte link and the `U_imem` write port / core reset.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/byte_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the imem boot loader / run controller.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int BPOS_W = 2;
  localparam int CNT_W  = 32;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four accepted stream bytes into a little-endian 32-bit word.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             accept,
  output logic [CNT_W-1:0] word,
  output logic             word_done
);

  logic [BPOS_W-1:0] bpos_reg;
  logic [23:0]       low_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bpos_reg <= '0;
    end else if (accept) begin
      bpos_reg <= bpos_reg + 1'b1;
    end
  end

  // Lower three byte lanes are stored; the top byte is taken straight from the bus.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          low_reg[8*gi +: 8] <= '0;
        end else if (accept && (bpos_reg == BPOS_W'(gi))) begin
          low_reg[8*gi +: 8] <= in_data;
        end
      end
    end
  endgenerate

  assign word      = {in_data, low_reg};
  assign word_done = accept && (&bpos_reg);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program into imem, releases the core, counts cycles
// until the write-back PC hits HALT_PC.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          AW      = 10,
  parameter logic [31:0] HALT_PC = 32'h000000ff
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   pcW,
  output logic          cpu_rstn,
  output logic          halted,
  output logic          err,
  output logic [31:0]   cycle_count
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   len_reg;
  logic [CNT_W-1:0]   idx_reg;
  logic               we_reg;
  logic [AW-1:0]      waddr_reg;
  logic [31:0]        wdata_reg;
  logic               err_reg;
  logic [31:0]        cyc_reg;

  logic               accept;
  logic [CNT_W-1:0]   word;
  logic               word_done;
  logic               in_range;
  logic               last_word;
  logic               data_word;

  assign accept    = in_valid & in_ready;
  // Index fits in imem when no bits at or above AW are set.
  assign in_range  = ((idx_reg >> AW) == '0);
  assign last_word = (idx_reg == (len_reg - 1'b1));
  assign data_word = (state_reg == ST_DATA) && word_done;

  byte_word_assembler u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .accept    (accept),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_LEN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LEN: begin
        if (word_done) begin
          state_next = (word != '0) ? ST_DATA : ST_START;
        end
      end
      ST_DATA: begin
        if (word_done && last_word) begin
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_RUN;
      ST_RUN: begin
        if (pcW == HALT_PC) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_LEN;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_rstn = 1'b0;
    halted   = 1'b0;
    case (state_reg)
      ST_LEN,
      ST_DATA: in_ready = 1'b1;
      ST_RUN:  cpu_rstn = 1'b1;
      ST_HALT: halted   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_reg   <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      we_reg <= data_word && in_range;
      if ((state_reg == ST_LEN) && word_done) begin
        len_reg <= word;
      end
      if (data_word) begin
        idx_reg <= idx_reg + 1'b1;
        if (in_range) begin
          waddr_reg <= idx_reg[AW-1:0];
          wdata_reg <= word;
        end else begin
          // Oversize words are still consumed to keep the stream aligned.
          err_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      cyc_reg <= cyc_reg + 1'b1;
    end
  end

  assign imem_we     = we_reg;
  assign imem_waddr  = waddr_reg;
  assign imem_wdata  = wdata_reg;
  assign err         = err_reg;
  assign cycle_count = cyc_reg;

endmodule
